// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU arbiter slice.
//   ALU_DW       : operand/result width that the request record is built for
//   ALU_*        : ALU opcode encodings. The arbiter passes these through
//                  without looking at them.
//   arb_state_t  : arbiter result-slot state (IDLE = empty, HOLD = result held)
//   alu_req_t    : one requester's ALU operation {alusrc, aluctrl, op1, imm, reg2}
package alu_pkg;
   localparam int ALU_DW = 32;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_SLL   = 4'b0001;
   localparam logic [3:0] ALU_SLT   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SRL   = 4'b0101;
   localparam logic [3:0] ALU_SRA   = 4'b1101;
   localparam logic [3:0] ALU_OR    = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b0111;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   typedef enum logic {IDLE, HOLD} arb_state_t;

   typedef struct packed {
      logic              alusrc;
      logic [3:0]        aluctrl;
      logic [ALU_DW-1:0] op1;
      logic [ALU_DW-1:0] imm;
      logic [ALU_DW-1:0] reg2;
   } alu_req_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: the bus between the requesters, the arbiter and the shared ALU.
//   req_*  : per-requester request channel (valid/ready plus operation fields)
//   alu_*  : operand/control to the ALU, alu_out/alu_eq back from it
//   rsp_*  : one-hot response channel carrying the registered result
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if #(
   parameter int D_WIDTH = 32,
   parameter int N_REQ   = 2
);
   logic [N_REQ-1:0]              req_valid;
   logic [N_REQ-1:0]              req_ready;
   logic [N_REQ-1:0]              req_alusrc;
   logic [N_REQ-1:0][3:0]         req_aluctrl;
   logic [N_REQ-1:0][D_WIDTH-1:0] req_op1;
   logic [N_REQ-1:0][D_WIDTH-1:0] req_imm;
   logic [N_REQ-1:0][D_WIDTH-1:0] req_reg2;

   logic                          alu_alusrc;
   logic [3:0]                    alu_aluctrl;
   logic [D_WIDTH-1:0]            alu_op1;
   logic [D_WIDTH-1:0]            alu_immop;
   logic [D_WIDTH-1:0]            alu_regop2;
   logic [D_WIDTH-1:0]            alu_out;
   logic                          alu_eq;

   logic [N_REQ-1:0]              rsp_valid;
   logic [N_REQ-1:0]              rsp_ready;
   logic [D_WIDTH-1:0]            rsp_data;
   logic                          rsp_eq;

   modport slave (
      input  req_valid, req_alusrc, req_aluctrl, req_op1, req_imm, req_reg2,
      output req_ready,
      output alu_alusrc, alu_aluctrl, alu_op1, alu_immop, alu_regop2,
      input  alu_out, alu_eq,
      output rsp_valid, rsp_data, rsp_eq,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_alusrc, req_aluctrl, req_op1, req_imm, req_reg2,
      input  req_ready,
      input  alu_alusrc, alu_aluctrl, alu_op1, alu_immop, alu_regop2,
      output alu_out, alu_eq,
      input  rsp_valid, rsp_data, rsp_eq,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-port grant logic for the ALU arbiter.
//   i_req       : request valids
//   i_ptr       : index of the last granted port; a tie goes to the other one
//   i_slot_free : result slot can take a new operation this cycle
//   o_gnt       : one-hot grant, zero when the slot is busy or no request
// Macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins a tie and i_ptr is ignored.
// Port 1 can then starve, which is acceptable for the execute path.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   input  logic       i_slot_free,
   output logic [1:0] o_gnt
);
`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = i_ptr;
`endif

   always_comb begin
      o_gnt = 2'b00;
      if (i_slot_free) begin
         case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   o_gnt = 2'b01;
`else
            2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
`endif
            default: o_gnt = 2'b00;
         endcase
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0)
// and the branch/address helper (port 1). There is one result slot, so only
// one operation is in flight at a time.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset. Drops any held result and sets the
//           tie-break so that port 0 wins the first tie.
//   bus   : alu_arbiter_if.slave. Carries the req_* channel in, the alu_*
//           operands out and the result back, and the rsp_* channel out.
// Operation: a request is granted when the slot is free. Its fields drive the
// ALU in the same cycle, and the ALU result is captured into rsp_* on that edge.
// The held result is released when its owner's rsp_ready is high. A new accept
// can happen in the same cycle, which gives back-to-back throughput.
// Macro ALU_ARB_FIXED_PRIO_EN: strict priority to port 0. No round-robin pointer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int N_REQ   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   alu_arbiter_if.slave bus
);
   generate
      if (N_REQ != 2) begin : g_nreq_chk
         $error("alu_arbiter: N_REQ must be 2");
      end
      // The request record in alu_pkg is built at ALU_DW.
      if (D_WIDTH != ALU_DW) begin : g_dw_chk
         $error("alu_arbiter: D_WIDTH must equal alu_pkg::ALU_DW");
      end
   endgenerate

   arb_state_t         r_state, w_nxt_state;
   logic [N_REQ-1:0]   r_rsp_valid;
   logic [D_WIDTH-1:0] r_rsp_data;
   logic               r_rsp_eq;
   logic               w_ptr;

   alu_req_t           w_req [N_REQ];
   alu_req_t           w_sel;
   logic [1:0]         w_gnt;
   logic               w_acc;
   logic               w_gidx;
   logic               w_consume;
   logic               w_slot_free;

   // Collect each port's fields into one request record.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_req[gi] = {bus.req_alusrc[gi], bus.req_aluctrl[gi],
                          bus.req_op1[gi], bus.req_imm[gi], bus.req_reg2[gi]};
   end

   // Only the owner's rsp_ready counts. rsp_valid is zero when the slot is IDLE.
   assign w_consume   = |(r_rsp_valid & bus.rsp_ready);
   assign w_slot_free = (r_state == IDLE) || ((r_state == HOLD) && w_consume);

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_ptr = 1'b1;
`else
   logic r_rr_ptr;
   assign w_ptr = r_rr_ptr;
`endif

   rr_arb2 u_arb (
      .i_req       (bus.req_valid),
      .i_ptr       (w_ptr),
      .i_slot_free (w_slot_free),
      .o_gnt       (w_gnt)
   );

   // A grant is only issued to a valid port. ready is the grant itself, so
   // any grant is an accept.
   assign bus.req_ready = w_gnt;
   assign w_acc         = |w_gnt;
   assign w_gidx        = w_gnt[1];

   // The ALU sees the winner's fields unmodified, and zeros when idle.
   assign w_sel           = w_acc ? w_req[w_gidx] : '0;
   assign bus.alu_alusrc  = w_sel.alusrc;
   assign bus.alu_aluctrl = w_sel.aluctrl;
   assign bus.alu_op1     = w_sel.op1;
   assign bus.alu_immop   = w_sel.imm;
   assign bus.alu_regop2  = w_sel.reg2;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE:    if (w_acc) w_nxt_state = HOLD;
         HOLD:    if (w_acc)          w_nxt_state = HOLD;
                  else if (w_consume) w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
   end

   // Result slot. On a plain consume, data/eq keep their last value and only
   // valid drops.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_eq    <= 1'b0;
      end else if (w_acc) begin
         r_rsp_valid <= w_gnt;
         r_rsp_data  <= bus.alu_out;
         r_rsp_eq    <= bus.alu_eq;
      end else if (w_consume) begin
         r_rsp_valid <= '0;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // The pointer moves only on an accept. A request withdrawn before it is
   // accepted leaves the pointer alone.
   always_ff @(posedge i_clk) begin
      if (i_rst)      r_rr_ptr <= 1'b1;
      else if (w_acc) r_rr_ptr <= w_gidx;
   end
`endif

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_eq    = r_rsp_eq;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: port 0 is the execute stage, port 1 is the branch/address helper.
- Arbitrates with round-robin priority, drives the ALU operand/control inputs from the granted request, and registers the ALU result.
- Returns the result to the winning requester over a valid/ready response channel.
- Sits between the pipeline stages and the ALU; only one operation is in flight at a time.

Parameters:
- D_WIDTH, 32, operand/result width.
- N_REQ, 2, number of requesters; fixed at 2, and the RTL asserts N_REQ == 2 at elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_alusrc  in  2x1  operand-2 select per requester.
- req_aluctrl  in  2x4  ALU opcode per requester.
- req_op1  in  2xD_WIDTH  operand 1.
- req_imm  in  2xD_WIDTH  immediate operand.
- req_reg2  in  2xD_WIDTH  register operand 2.
- alu_alusrc  out  1  to ALU.
- alu_aluctrl  out  4  to ALU.
- alu_op1, alu_immop, alu_regop2  out  D_WIDTH each  to ALU.
- alu_out  in  D_WIDTH  from ALU.
- alu_eq  in  1  from ALU.
- rsp_valid  out  2  one-hot response valid (owner of the result).
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  D_WIDTH  registered ALU result.
- rsp_eq  out  1  registered ALU eq flag.

Behaviour:
- States: IDLE (no result held) and HOLD (result registered, awaiting consumer).
- Reset (rst=1 at a clock edge):
  - State becomes IDLE; rsp_valid=0; rsp_data=0; rsp_eq=0; rr_ptr=1, so port 0 wins the first tie.
  - Any held result is discarded; the requester must re-issue.
  - rst dominates all handshakes in that cycle.
- Slot free = (state==IDLE) or (state==HOLD and the owning rsp_ready is high this cycle).
- Grant, combinational:
  - If the slot is free and exactly one req_valid is high, that port is granted.
  - If both are high, grant the port != rr_ptr.
  - req_ready = one-hot grant, else 0.
  - Grant never depends on req_ready.
- Accept = req_valid & req_ready on the granted port. In the same cycle, alu_* outputs carry the granted port's fields, unmodified.
- When there is no accept, alu_* outputs are driven to 0 (alusrc=0, aluctrl=4'b0000).
- On the accept edge:
  - rsp_data <= alu_out; rsp_eq <= alu_eq.
  - rsp_valid <= one-hot of the granted port; rr_ptr <= granted index; state <= HOLD.
- Latency: result visible on rsp_* the cycle after accept. Throughput is 1 op/cycle while the owner holds rsp_ready high (response consume and new accept happen in the same cycle).
- HOLD:
  - rsp_valid, rsp_data and rsp_eq are stable until the owning rsp_ready is high.
  - rsp_ready on the non-owning port is ignored.
  - On consume with no new accept: rsp_valid <= 0 and state <= IDLE. rsp_data/rsp_eq keep their last value.
- Requester rules:
  - A requester must hold req_valid and its fields stable until accepted.
  - Deasserting before accept is legal; the request is simply not served and does not move rr_ptr.
- The arbiter does not interpret aluctrl. Unknown opcodes are passed through, and whatever alu_out returns is captured.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined:
  - Strict priority: port 0 always wins a tie.
  - rr_ptr is removed.
  - Port 1 can starve; this is by design for the execute path.
- Undefined: round-robin as specified above.
- The port list is identical in both builds.

Decomposition:
- Package alu_pkg:
  - ALU opcode localparams: ALU_ADD 4'b0000, ALU_SUB 4'b1000, ALU_SLL 4'b0001, ALU_SLT 4'b0010, ALU_SLTU 4'b0011, ALU_XOR 4'b0100, ALU_SRL 4'b0101, ALU_SRA 4'b1101, ALU_OR 4'b0110, ALU_AND 4'b0111, ALU_PASSB 4'b1111.
  - Enum arb_state_t {IDLE, HOLD}.
  - Struct alu_req_t {alusrc, aluctrl, op1, imm, reg2}.
- One sub-module, rr_arb2:
  - Inputs: req[1:0], ptr, slot_free.
  - Output: gnt[1:0].
  - Contains the fixed-priority macro switch.

Test Plan:
1. Reset, then port 0 only: op1=5, reg2=3, aluctrl=ADD, alusrc=0. Expect req_ready=2'b01 in the same cycle; next cycle rsp_valid=2'b01, rsp_data=8.
2. Both valid at once: port0 SUB 10-4, port1 OR with imm 0xF0, op1 0x0F, alusrc=1. Expect port 0 granted first (rsp_data=6), port 1 next cycle (rsp_data=0xFF).
3. Fairness: both valid continuously with rsp_ready=2'b11 for 8 cycles. Expect grants to alternate 0,1,0,1…; one response per cycle; no bubbles.
4. Backpressure: hold rsp_ready[0]=0 for 3 cycles with port 1 valid. Expect req_ready=0, rsp_data stable at the first result, and port 1 accepted in the cycle rsp_ready[0] rises.
5. Reset in HOLD: port 0 result 0x1234 pending, pulse rst. Expect rsp_valid=0, rsp_data=0 next cycle, and the next tie granted to port 0.
6. Build with ALU_ARB_FIXED_PRIO_EN, both valid for 4 cycles. Expect port 0 granted every cycle and port 1 never granted.
